no_itk_param: RTL
=================

# no_itk_param

Parametrised gene-regulatory-network node holding two copies of its state: a slow copy (s0) and a fast copy (s1), used for tortoise/hare attractor detection. Generalises the 1-bit, fixed divide-by-2 node to a multi-valued state of WIDTH bits and a runtime-selectable slow-copy divider. Adds per-copy saturating transition counters and a sticky slow/fast coincidence flag. Sits in the network array: each node is fed by its neighbours' next-state logic and drives its own state back into that logic.

## Interface
- WIDTH, 1: bits per state copy (multi-valued logic level).
- DIV_W, 4: width of the slow-copy divider select.
- CNT_W, 16: width of each transition counter.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- reset_nos  in  1  network re-initialise strobe.
- init_state  in  WIDTH  value loaded into both copies on reset_nos.
- div  in  DIV_W  slow-copy divider (0 treated as 1); sampled only on reset_nos.
- start_s0  in  1  slow-copy step strobe.
- start_s1  in  1  fast-copy step strobe.
- next_s0  in  WIDTH  next-state function evaluated on s0 inputs.
- next_s1  in  WIDTH  next-state function evaluated on s1 inputs.
- s0  out  WIDTH  slow-copy state (registered).
- s1  out  WIDTH  fast-copy state (registered).
- itk_s0, itk_s1  out  WIDTH  copies of s0/s1 for neighbour logic.
- chg_s0, chg_s1  out  CNT_W  count of value-changing updates per copy, saturating.
- match  out  1  combinational s0 == s1.
- cycle_found  out  1  sticky: coincidence seen after at least one fast step.

## Operation
- Priority per cycle: rst > reset_nos > start strobes.
- rst: s0=s1=0, div_q=1, phase=0, chg_s0=chg_s1=0, stepped=0, cycle_found=0.
- reset_nos: s0,s1 <= init_state; div_q <= (div==0 ? 1 : div); phase <= 0; both counters 0; stepped <= 0; cycle_found <= 0. Any start strobe in the same cycle is ignored.
- Slow copy (start_s0, no reset_nos): if phase==0 then s0 <= next_s0, phase <= div_q-1; else phase <= phase-1, s0 holds. div_q=2: updates on strobes 1,3,5,...; div_q=1: every strobe.
- Fast copy (start_s1, no reset_nos): s1 <= next_s1 every strobe; stepped <= 1.
- start_s0 and start_s1 are independent; both may act in the same cycle.
- chg_sX increments by 1 when copy X is written with a value different from its current value; holds at 2^CNT_W-1. Writes of an identical value do not count.
- cycle_found sets on any cycle where stepped==1 and registered s0==s1; remains set until rst or reset_nos.
- div changes outside reset_nos have no effect.
- Width rules: next_sX taken whole, no truncation; phase is DIV_W bits; div_q never 0.

## Timing
- State update latency: 1 cycle from strobe to new s0/s1 (and itk_*).
- Counter update in the same edge as the state write.
- match follows registered s0/s1 combinationally (0 cycles after state change).
- cycle_found asserts 1 cycle after the first qualifying match (registered).
- reset_nos mid-sequence: divider phase restarts; the next start_s0 always updates s0.
- All outputs valid the cycle after rst deasserts with values listed above.

## Test plan
- rst, then reset_nos with init_state=3 (WIDTH=2), div=2; six start_s0 pulses with next_s0=1,2,3,0,1,2 -> s0 takes 1 (pulse 1), 3 (pulse 3), 1 (pulse 5); chg_s0=3.
- div=0 at reset_nos; start_s0 every cycle with next_s0 incrementing -> s0 updates on every pulse (treated as div 1).
- start_s0 and start_s1 together with reset_nos asserted -> s0=s1=init_state, counters 0, divider phase 0.
- Fast copy driven with next_s1 = s1 (no change) for 10 pulses -> chg_s1 stays 0; CNT_W=4 with 20 changing writes -> chg_s1 saturates at 15.
- Tortoise/hare: s0 div=2, s1 every pulse, 4-state ring 0->1->2->3->0 -> cycle_found asserts one cycle after first s0==s1 post-step; holds through further strobes; clears on reset_nos.
- rst asserted mid-run between strobes -> all outputs return to reset values next cycle; cycle_found=0.

Source files
------------

// File: rtl/no_itk_param.sv
// Gene-regulatory-network node keeping a slow (divided) and a fast copy of its
// multi-valued state, with change counters and a sticky slow/fast coincidence flag.
module no_itk_param #(
  parameter int WIDTH = 1,
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic [WIDTH-1:0] init_state,
  input  logic [DIV_W-1:0] div,
  input  logic             start_s0,
  input  logic             start_s1,
  input  logic [WIDTH-1:0] next_s0,
  input  logic [WIDTH-1:0] next_s1,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] itk_s0,
  output logic [WIDTH-1:0] itk_s1,
  output logic [CNT_W-1:0] chg_s0,
  output logic [CNT_W-1:0] chg_s1,
  output logic             match,
  output logic             cycle_found
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_s0;
  logic [WIDTH-1:0] r_s1;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_phase;
  logic [CNT_W-1:0] r_chg_s0;
  logic [CNT_W-1:0] r_chg_s1;
  logic             r_stepped;
  logic             r_cycle_found;

  logic             w_match;
  logic [DIV_W-1:0] w_div_eff;

  assign w_match   = (r_s0 == r_s1);
  // A zero divider would stall the slow copy forever, so it behaves as 1.
  assign w_div_eff = (div == '0) ? DIV_ONE : div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0          <= '0;
      r_s1          <= '0;
      r_div_q       <= DIV_ONE;
      r_phase       <= '0;
      r_chg_s0      <= '0;
      r_chg_s1      <= '0;
      r_stepped     <= 1'b0;
      r_cycle_found <= 1'b0;
    end else if (reset_nos) begin
      r_s0          <= init_state;
      r_s1          <= init_state;
      r_div_q       <= w_div_eff;
      r_phase       <= '0;
      r_chg_s0      <= '0;
      r_chg_s1      <= '0;
      r_stepped     <= 1'b0;
      r_cycle_found <= 1'b0;
    end else begin
      // Both copies start equal, so a match only counts once the hare has moved.
      if (r_stepped && w_match) begin
        r_cycle_found <= 1'b1;
      end

      if (start_s0) begin
        if (r_phase == '0) begin
          r_s0    <= next_s0;
          r_phase <= r_div_q - DIV_ONE;
          if ((next_s0 != r_s0) && (r_chg_s0 != CNT_MAX)) begin
            r_chg_s0 <= r_chg_s0 + CNT_ONE;
          end
        end else begin
          r_phase <= r_phase - DIV_ONE;
        end
      end

      if (start_s1) begin
        r_s1      <= next_s1;
        r_stepped <= 1'b1;
        if ((next_s1 != r_s1) && (r_chg_s1 != CNT_MAX)) begin
          r_chg_s1 <= r_chg_s1 + CNT_ONE;
        end
      end
    end
  end

  assign s0          = r_s0;
  assign s1          = r_s1;
  assign itk_s0      = r_s0;
  assign itk_s1      = r_s1;
  assign chg_s0      = r_chg_s0;
  assign chg_s1      = r_chg_s1;
  assign match       = w_match;
  assign cycle_found = r_cycle_found;

endmodule
